// File: rtl/mapped_spi_flash_pkg.sv
// mapped_spi_flash_pkg: shared opcodes, bit counts, FSM states and helpers for the SPI flash port
// Build option: SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy bits.
package mapped_spi_flash_pkg;
    localparam logic [7:0] READ_OP = 8'h03;
    localparam logic [7:0] FAST_READ_OP = 8'h0B;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [7:0] OPCODE = FAST ? FAST_READ_OP : READ_OP;
    localparam int ADDR_BITS = 24;
    localparam int DUMMY_BITS = FAST ? 8 : 0;
    localparam int RECV_BITS = 32;
    localparam int SEND_BITS = 8 + ADDR_BITS + DUMMY_BITS;
    localparam int TOTAL_BITS = SEND_BITS + RECV_BITS;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

    function automatic logic [SEND_BITS-1:0] send_word(input logic [19:0] wa);
`ifdef SPI_FLASH_FAST_READ_EN
        return {OPCODE, 2'b00, wa, 2'b00, 8'h00};
`else
        return {OPCODE, 2'b00, wa, 2'b00};
`endif
    endfunction

    // Flash delivers byte a first into the MSBs; the bus wants it in the LSBs.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
endpackage

// File: rtl/mapped_spi_flash_shifter.sv
// spi_flash_shifter: SPI mode-0 bit engine (bit counter, CLK phase, shift-out, shift-in)
// Ports: clk/reset; start loads send word; active runs the bit engine;
//        sck = serial clock, mosi = current out bit, bit_cnt = completed bits, rx = last 32 bits in.
module spi_flash_shifter
    import mapped_spi_flash_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 active,
    input  logic [SEND_BITS-1:0] load,
    input  logic                 miso,
    output logic                 sck,
    output logic                 mosi,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic [31:0]          rx
);
    logic [SEND_BITS-1:0] sout;

    // The edge raising sck samples MISO; the edge lowering it advances to the next bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck <= 1'b0;
            bit_cnt <= '0;
            sout <= '0;
            rx <= '0;
        end else if (start) begin
            sck <= 1'b0;
            bit_cnt <= '0;
            sout <= load;
        end else if (active) begin
            if (!sck) begin
                sck <= 1'b1;
                rx <= {rx[30:0], miso};
            end else begin
                sck <= 1'b0;
                bit_cnt <= bit_cnt + 1'b1;
                sout <= sout << 1;
            end
        end
    end

    assign mosi = sout[SEND_BITS-1];
endmodule

// File: rtl/mapped_spi_flash.sv
// mapped_spi_flash: memory-mapped read-only SPI flash port returning little-endian 32-bit words
// Ports: clk, reset (sync, active high); rstrb + word_address start a read while idle;
//        rdata/rbusy to the bus; CLK/CS_N/MOSI/MISO to the flash.
// Build option: SPI_FLASH_FAST_READ_EN (FAST_READ with dummy byte, 144-cycle reads).
module mapped_spi_flash
    import mapped_spi_flash_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rstrb,
    input  logic [19:0] word_address,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        CLK,
    output logic        CS_N,
    output logic        MOSI,
    input  logic        MISO
);
    state_t state, next;
    logic [CNT_W-1:0] bit_cnt;
    logic [31:0] rx;
    logic mosi_raw, start, bit_end;

    assign start = state == IDLE && rstrb;
    assign bit_end = CLK;

    spi_flash_shifter u_shift (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .active  (state != IDLE),
        .load    (send_word(word_address)),
        .miso    (MISO),
        .sck     (CLK),
        .mosi    (mosi_raw),
        .bit_cnt (bit_cnt),
        .rx      (rx)
    );

    always_comb begin
        next = state;
        next = start ? SEND :
               (state == SEND && bit_end && bit_cnt == CNT_W'(SEND_BITS - 1)) ? RECV :
               (state == RECV && bit_end && bit_cnt == CNT_W'(TOTAL_BITS - 1)) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rdata <= '0;
        end else begin
            state <= next;
            if (state == RECV && next == IDLE) rdata <= bswap32(rx);
        end
    end

    assign rbusy = state != IDLE;
    assign CS_N = state == IDLE;
    assign MOSI = state == SEND && mosi_raw;
endmodule

// File: tb/tb_mapped_spi_flash.sv
// tb_mapped_spi_flash: directed bench with behavioural mode-0 flash model and rdata scoreboard
module tb_mapped_spi_flash;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OP = 8'h0B;
    localparam int NSEND = 40;
`else
    localparam logic [7:0] OP = 8'h03;
    localparam int NSEND = 32;
`endif
    localparam int BUSY = 2 * (NSEND + 32);

    logic clk = 1'b0, reset = 1'b1, rstrb = 1'b0, MISO = 1'b0;
    logic [19:0] word_address = '0;
    logic [31:0] rdata;
    logic rbusy, CLK, CS_N, MOSI;

    mapped_spi_flash dut (
        .clk(clk), .reset(reset), .rstrb(rstrb), .word_address(word_address),
        .rdata(rdata), .rbusy(rbusy), .CLK(CLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    // Flash model: samples MOSI on CLK rise, drives MISO on CLK fall.
    logic [7:0] mem [256];
    logic [63:0] mosi_sh;
    logic [7:0] m_op;
    logic [23:0] m_addr;
    int bitn = 0, win_rises = 0, mosi_bad = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    always @(negedge CS_N) bitn = 0;
    always @(posedge CS_N) win_rises = bitn;

    always @(posedge CLK) if (!CS_N) begin
        if (bitn >= 32 && MOSI !== 1'b0) mosi_bad++;
        mosi_sh = {mosi_sh[62:0], MOSI};
        bitn++;
    end

    always @(negedge CLK) if (!CS_N) begin
        int r;
        if (bitn == NSEND) begin
            m_addr = mosi_sh[NSEND-32 +: 24];
            m_op = mosi_sh[NSEND-8 +: 8];
        end
        r = bitn - NSEND;
        if (r >= 0 && r < 32) MISO = mem[8'(m_addr + 24'(r / 8))][7 - r % 8];
    end

    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [19:0] wa);
        logic [7:0] a;
        a = 8'({wa, 2'b00});
        return {a + 8'd3, a + 8'd2, a + 8'd1, a};
    endfunction

    task automatic read_txn(input logic [19:0] wa, input bit inject);
        int cyc;
        exp_q.push_back(exp_word(wa));
        @(negedge clk);
        word_address = wa;
        rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        chk("start_busy", 32'(rbusy), 32'd1);
        chk("start_cs", 32'(CS_N), 32'd0);
        chk("start_clk", 32'(CLK), 32'd0);
        chk("start_mosi", 32'(MOSI), 32'(OP[7]));
        cyc = 1;
        while (rbusy === 1'b1 && cyc < 400) begin
            @(negedge clk);
            if (inject && cyc == 9) begin
                rstrb = 1'b1;
                word_address = 20'd20;
            end else rstrb = 1'b0;
            if (cyc == 64) chk("rdata_hold", rdata, last_rdata);
            if (rbusy === 1'b1) cyc++;
        end
        chk("busy_len", 32'(cyc), 32'(BUSY));
        chk("rdata", rdata, exp_q.pop_front());
        last_rdata = exp_word(wa);
        chk("end_cs", 32'(CS_N), 32'd1);
        chk("end_clk", 32'(CLK), 32'd0);
        chk("rises", 32'(win_rises), 32'(NSEND + 32));
        chk("opcode", 32'(m_op), 32'(OP));
        chk("addr", 32'(m_addr), 32'({2'b00, wa, 2'b00}));
        if (NSEND > 32) chk("dummy", 32'(mosi_sh[39:32]), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cs", 32'(CS_N), 32'd1);
        chk("rst_clk", 32'(CLK), 32'd0);
        chk("rst_busy", 32'(rbusy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        read_txn(20'd0, 1'b0);
        read_txn(20'd5, 1'b0);
        for (int i = 0; i < 32; i++) read_txn(20'(i), 1'b0);
        read_txn(20'd9, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_queue", 32'(rbusy), 32'd0);
        end
        @(negedge clk);
        word_address = 20'd3;
        rstrb = 1'b1;
        @(negedge clk);
        rstrb = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cs", 32'(CS_N), 32'd1);
        chk("abort_busy", 32'(rbusy), 32'd0);
        chk("abort_clk", 32'(CLK), 32'd0);
        chk("abort_mosi", 32'(MOSI), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        reset = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        read_txn(20'd7, 1'b0);
        chk("mosi_idle_zero", 32'(mosi_bad), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mapped_spi_flash.md
# mapped_spi_flash

Read-only, memory-mapped SPI flash port. It converts a one-cycle read strobe with a 20-bit word address into a single-SPI flash read transaction and returns a little-endian 32-bit word. It sits between the processor data/instruction bus and the external SPI flash pins, and is used for execute-in-place and constant data.

## Interface
Parameters: none; build-time option under Configuration.

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rstrb  in  1  read strobe, one clk wide; sampled only while idle
- word_address  in  20  32-bit word index; byte address = {2'b00, word_address, 2'b00} (24 bits)
- rdata  out  32  last word read; stable while rbusy=0
- rbusy  out  1  high while a transaction is in progress
- CLK  out  1  SPI serial clock, mode 0, idles low
- CS_N  out  1  flash chip select, active low
- MOSI  out  1  serial data to flash
- MISO  in  1  serial data from flash

## Operation
- States:
  - IDLE → SEND on rstrb=1.
  - SEND (command + address, plus dummy bits if configured) → RECV when all send bits are shifted.
  - RECV (32 bits) → IDLE.
- Reset values: CS_N=1, CLK=0, MOSI=0, rbusy=0, rdata=0, state IDLE.
- Reset asserted mid-transaction aborts it on that edge:
  - Outputs return to reset values.
  - rdata is cleared.
- Send word: 8-bit opcode 0x03, then the 24-bit byte address; MSB first.
- Receive: 32 bits, MSB first per byte. Byte order is little-endian:
  - Flash bytes B0..B3 at addresses a..a+3.
  - rdata = {B3,B2,B1,B0}.
- rstrb while rbusy=1: ignored; no queueing.
- rdata is updated only at transaction completion and holds until the next completion.
- MOSI is driven 0 outside SEND.

## Timing
- Bit period = 2 clk cycles:
  - Cycle 1: CLK=0; MOSI changes at the start of this cycle.
  - Cycle 2: CLK=1.
  - SCK = clk/2.
- MISO is sampled on the clk edge that drives CLK 0→1. The flash then has a full clk cycle after its falling-edge update.
- Edge E0 = rising clk edge at which rstrb=1 is sampled in IDLE. After E0:
  - CS_N=0, rbusy=1, CLK=0.
  - MOSI = opcode bit 7.
- Bit k occupies the cycles after E(2k) and E(2k+1).
- Standard read: 64 bits. At E128:
  - CS_N=1, CLK=0, rbusy=0.
  - rdata is valid.
- rbusy stays high for exactly 128 cycles.
- CS_N stays high for at least 1 cycle. The next strobe is accepted at E129 or later.

## Configuration
- SPI_FLASH_FAST_READ_EN defined:
  - Opcode 0x0B.
  - Address followed by 8 dummy bits, MOSI=0.
  - Send phase 40 bits; total 72 bits.
  - rbusy high 144 cycles; completion at E144.
- SPI_FLASH_FAST_READ_EN undefined: opcode 0x03, no dummy bits, 128-cycle transaction.

## Structure
- Shared package holds:
  - Opcodes READ=0x03 and FAST_READ=0x0B.
  - Send/dummy/receive bit counts.
  - State enum (IDLE, SEND, RECV).
- One natural sub-module, spi_flash_shifter:
  - Bit counter.
  - CLK phase toggle.
  - Shift-out register.
  - Shift-in register.
- The top level holds the FSM, address formatting and byte swap.

## Test plan
Bench uses a behavioural SPI flash model, mode 0, preloaded with byte i = i.
- Reset held high 3 cycles, then released → CS_N=1, CLK=0, rbusy=0, rdata=0.
- rstrb=1 for 1 cycle, word_address=0 → MOSI stream 0x03,0x00,0x00,0x00 → rbusy high 128 cycles → rdata=0x03020100.
- word_address=0x00005 → address bytes 0x00,0x00,0x14 → rdata=0x17161514.
- Loop i=0..31, strobe each after the previous rbusy falls → rdata=0x(4i+3)(4i+2)(4i+1)(4i) for every i; CLK has exactly 64 rising edges per CS_N-low window.
- Second rstrb pulsed at cycle 10 of a transaction → ignored; completion still at E128; no extra transaction.
- Reset at cycle 50 of a transaction → CS_N=1, rbusy=0 next edge; a new strobe then completes normally.
- With SPI_FLASH_FAST_READ_EN → opcode 0x0B, 8 dummy clocks, rbusy high 144 cycles, same rdata values.
